deconv_2d: RTL and testbench
============================

DECONV_2D -- requirements
Module: deconv_2d

Interface
REQ-001 Parameter N, default 2: input image side length (N x N pixels).
REQ-002 Parameter K, default 3: maximum kernel side length.
REQ-003 Parameter pixel_bits, default 8: pixel and weight width.
REQ-004 Ports SHALL be, one per line:
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  reset; asynchronous, active-low.
  enable  in  1  run request; high starts/continues an operation, low aborts to idle.
  strobe_signal_pixel  in  1  one-cycle pixel-valid pulse.
  strobe_signal_kernel  in  1  one-cycle weight-valid pulse.
  pixel  in  pixel_bits  unsigned pixel value.
  stride  in  clog2(K)  unsigned stride, legal range 1..K.
  kernel_width  in  clog2(K)  unsigned kernel side, legal range 1..K.
  kernel_weight  in  pixel_bits  unsigned weight value.
  pixel_number  in  clog2(N*N)  row-major input pixel index.
  result_address  in  clog2(N*K*N*K)  result RAM read address.
  final_output  out  4*pixel_bits  result RAM word at result_address.
  ready  out  1  block can accept a kernel or pixel strobe.
  done  out  1  all N*N pixels accumulated.

Function
REQ-005 Result RAM: N*K*N*K words of 4*pixel_bits; element (row,col) stored at row*(N*K)+col.
REQ-006 Kernel RAM: K*K words of pixel_bits; weight (i,j) stored at i*kernel_width+j.
REQ-007 final_output SHALL be a combinational read of result RAM[result_address], valid in every state; addresses >= N*K*N*K return 0.
REQ-008 States: IDLE, CLEAR_RAM, LOAD_KERNEL, WAIT_PIXEL, ACCUM, DONE.
REQ-009 IDLE: ready=0, done=0; enable sampled high -> CLEAR_RAM; stride and kernel_width captured on that edge and held for the whole operation.
REQ-010 CLEAR_RAM: one word zeroed per cycle, N*K*N*K cycles, ready=0; then -> LOAD_KERNEL.
REQ-011 LOAD_KERNEL: ready=1; each edge sampling strobe_signal_kernel=1 writes kernel_weight to the next kernel slot (row-major from 0); after kernel_width^2 weights -> WAIT_PIXEL.
REQ-012 WAIT_PIXEL: ready=1; edge sampling strobe_signal_pixel=1 captures pixel and pixel_number -> ACCUM.
REQ-013 ACCUM: ready=0; one kernel tap per cycle, kernel_width^2 cycles; for pixel (r,c)=(pixel_number/N, pixel_number%N) and tap (i,j): RAM[(r*stride+i)*N*K + c*stride+j] += pixel*weight(i,j).
REQ-014 Product is unsigned 2*pixel_bits, zero-extended; sum wraps modulo 2^(4*pixel_bits).
REQ-015 One-entry pending buffer: a pixel strobe sampled during ACCUM SHALL be captured if the buffer is empty (and dropped if full) and processed immediately after the current pixel without returning through WAIT_PIXEL.
REQ-016 Accepted pixels are counted (duplicated pixel_number values allowed); after the N*N-th pixel finishes ACCUM -> DONE.
REQ-017 DONE: done=1, ready=0; strobes ignored; RAM retained.
REQ-018 Strobes in states other than those above are ignored.
REQ-019 enable sampled low in any non-IDLE state -> IDLE next cycle; RAM contents retained, done and ready cleared, counters and pending buffer cleared.
REQ-020 Computed write addresses with column >= N*K or address >= N*K*N*K SHALL be discarded.

Reset
REQ-021 rst low asynchronously forces IDLE, ready=0, done=0, all counters, pending buffer, kernel RAM and result RAM to 0; final_output reads 0.
REQ-022 Operation restarts only after rst high and enable sampled high.

Verification
REQ-023 N=2,K=3,stride=1,kernel_width=2, weights 1,1,1,1, pixels 10,20,30,40 (indices 0..3) -> done; addr 0=10, 1=30, 2=20, 6=40, 7=100, 8=60, 12=30, 13=70, 14=40; all others 0.
REQ-024 Same weights, stride=2, kernel_width=2, pixels 1,2,3,4 -> addrs 0,1,6,7=1; 2,3,8,9=2; 12,13,18,19=3; 14,15,20,21=4; all others 0.
REQ-025 enable rise -> ready low exactly 36 cycles (CLEAR_RAM), then high; previously nonzero words read 0.
REQ-026 Pixel strobe issued one cycle after a prior accept (during ACCUM) -> still processed; final result identical to REQ-023.
REQ-027 Drop enable mid-ACCUM -> IDLE next cycle, done=0, ready=0; rst low mid-operation -> all outputs 0 immediately.
REQ-028 Weight 255, pixel 255, kernel_width=1, all four pixels at index 0 -> addr 0 = 4*65025 = 260100, no truncation.

Source files
------------

// File: rtl/deconv_2d.sv
// rtl/deconv_2d.sv - 2-D transposed convolution: kernel load, per-pixel scatter-accumulate into result RAM
module deconv_2d #(
    parameter int N          = 2,
    parameter int K          = 3,
    parameter int pixel_bits = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            strobe_signal_pixel,
    input  logic                            strobe_signal_kernel,
    input  logic [pixel_bits-1:0]           pixel,
    input  logic [$clog2(K)-1:0]            stride,
    input  logic [$clog2(K)-1:0]            kernel_width,
    input  logic [pixel_bits-1:0]           kernel_weight,
    input  logic [$clog2(N*N)-1:0]          pixel_number,
    input  logic [$clog2(N*K*N*K)-1:0]      result_address,
    output logic [4*pixel_bits-1:0]         final_output,
    output logic                            ready,
    output logic                            done
);
    localparam int NK  = N * K;
    localparam int NK2 = NK * NK;
    localparam int SW  = $clog2(K);
    localparam int PNW = $clog2(N * N);
    localparam int RAW = $clog2(NK2);
    localparam int KAW = $clog2(K * K);
    localparam int CW  = $clog2(N * N + 1);
    localparam int OW  = 4 * pixel_bits;
    localparam int PW  = 2 * pixel_bits;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_WAIT, S_ACCUM, S_DONE
    } state_t;

    state_t                state;
    logic [OW-1:0]         res_ram [NK2];
    logic [pixel_bits-1:0] k_ram [K*K];
    logic [SW-1:0]         stride_q, kw_q, tap_i, tap_j;
    logic [RAW-1:0]        clr_cnt;
    logic [KAW-1:0]        k_cnt;
    logic [CW-1:0]         pix_cnt;
    logic [pixel_bits-1:0] cur_pix, pend_pix;
    logic [PNW-1:0]        cur_num, pend_num;
    logic                  pend_valid;

    logic [31:0]           row_idx, col_idx, wr_addr, taps;
    logic [KAW-1:0]        w_idx;
    logic [pixel_bits-1:0] w_cur;
    logic [PW-1:0]         prod;
    logic [OW-1:0]         acc_sum;
    logic                  wr_ok, last_tap;

    // Scatter target of the current tap; out-of-image columns/rows are discarded.
    always_comb begin
        row_idx  = (32'(cur_num) / 32'(N)) * 32'(stride_q) + 32'(tap_i);
        col_idx  = (32'(cur_num) % 32'(N)) * 32'(stride_q) + 32'(tap_j);
        wr_addr  = row_idx * 32'(NK) + col_idx;
        wr_ok    = (col_idx < 32'(NK)) && (wr_addr < 32'(NK2));
        w_idx    = KAW'(32'(tap_i) * 32'(kw_q) + 32'(tap_j));
        w_cur    = k_ram[w_idx];
        prod     = {{pixel_bits{1'b0}}, cur_pix} * {{pixel_bits{1'b0}}, w_cur};
        acc_sum  = res_ram[wr_addr[RAW-1:0]] + {{PW{1'b0}}, prod};
        taps     = 32'(kw_q) * 32'(kw_q);
        last_tap = (tap_i == kw_q - SW'(1)) && (tap_j == kw_q - SW'(1));
    end

    assign final_output = (32'(result_address) < 32'(NK2)) ? res_ram[result_address] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ready      <= 1'b0;
            done       <= 1'b0;
            stride_q   <= '0;
            kw_q       <= '0;
            tap_i      <= '0;
            tap_j      <= '0;
            clr_cnt    <= '0;
            k_cnt      <= '0;
            pix_cnt    <= '0;
            cur_pix    <= '0;
            cur_num    <= '0;
            pend_pix   <= '0;
            pend_num   <= '0;
            pend_valid <= 1'b0;
            for (int a = 0; a < NK2; a++) res_ram[a] <= '0;
            for (int a = 0; a < K*K; a++) k_ram[a] <= '0;
        end else if (state != S_IDLE && !enable) begin
            state      <= S_IDLE;
            ready      <= 1'b0;
            done       <= 1'b0;
            tap_i      <= '0;
            tap_j      <= '0;
            clr_cnt    <= '0;
            k_cnt      <= '0;
            pix_cnt    <= '0;
            pend_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        stride_q <= stride;
                        kw_q     <= kernel_width;
                        clr_cnt  <= '0;
                        state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    res_ram[clr_cnt] <= '0;
                    if (32'(clr_cnt) == 32'(NK2 - 1)) begin
                        k_cnt <= '0;
                        ready <= 1'b1;
                        state <= S_LOAD;
                    end else begin
                        clr_cnt <= clr_cnt + RAW'(1);
                    end
                end
                S_LOAD: begin
                    if (strobe_signal_kernel) begin
                        k_ram[k_cnt] <= kernel_weight;
                        if (32'(k_cnt) == taps - 32'd1) begin
                            k_cnt <= '0;
                            state <= S_WAIT;
                        end else begin
                            k_cnt <= k_cnt + KAW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (strobe_signal_pixel) begin
                        cur_pix <= pixel;
                        cur_num <= pixel_number;
                        tap_i   <= '0;
                        tap_j   <= '0;
                        ready   <= 1'b0;
                        state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (wr_ok) res_ram[wr_addr[RAW-1:0]] <= acc_sum;
                    if (!last_tap) begin
                        if (tap_j == kw_q - SW'(1)) begin
                            tap_j <= '0;
                            tap_i <= tap_i + SW'(1);
                        end else begin
                            tap_j <= tap_j + SW'(1);
                        end
                        if (strobe_signal_pixel && !pend_valid) begin
                            pend_pix   <= pixel;
                            pend_num   <= pixel_number;
                            pend_valid <= 1'b1;
                        end
                    end else begin
                        tap_i   <= '0;
                        tap_j   <= '0;
                        pix_cnt <= pix_cnt + CW'(1);
                        if (32'(pix_cnt) == 32'(N*N - 1)) begin
                            pend_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else if (pend_valid) begin
                            cur_pix    <= pend_pix;
                            cur_num    <= pend_num;
                            pend_valid <= 1'b0;
                        end else if (strobe_signal_pixel) begin
                            // Empty buffer on the last tap: the strobe becomes the next pixel directly.
                            cur_pix <= pixel;
                            cur_num <= pixel_number;
                        end else begin
                            ready <= 1'b1;
                            state <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_deconv_2d.sv
// tb/tb_deconv_2d.sv - directed and randomized checks of deconv_2d against a scatter-accumulate model
module tb_deconv_2d;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        strobe_signal_pixel;
    logic        strobe_signal_kernel;
    logic [7:0]  pixel;
    logic [1:0]  stride;
    logic [1:0]  kernel_width;
    logic [7:0]  kernel_weight;
    logic [1:0]  pixel_number;
    logic [5:0]  result_address;
    logic [31:0] final_output;
    logic        ready;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_ram [36];
    int w_arr [9];
    int px_val [4];
    int px_idx [4];

    deconv_2d #(.N(2), .K(3), .pixel_bits(8)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .strobe_signal_pixel(strobe_signal_pixel),
        .strobe_signal_kernel(strobe_signal_kernel),
        .pixel(pixel), .stride(stride), .kernel_width(kernel_width),
        .kernel_weight(kernel_weight), .pixel_number(pixel_number),
        .result_address(result_address), .final_output(final_output),
        .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each pixel spreads pixel*weight(i,j) over a kernel-sized window anchored at (r*stride, c*stride).
    task automatic model_calc(input int s, input int kw, input int np);
        for (int a = 0; a < 36; a++) ref_ram[a] = 32'd0;
        for (int p = 0; p < np; p++) begin
            int r, c;
            r = px_idx[p] / 2;
            c = px_idx[p] % 2;
            for (int i = 0; i < kw; i++)
                for (int j = 0; j < kw; j++) begin
                    int row, col;
                    row = r * s + i;
                    col = c * s + j;
                    if (col < 6 && row * 6 + col < 36)
                        ref_ram[row * 6 + col] += 32'(px_val[p] * w_arr[i * kw + j]);
                end
        end
    endtask

    task automatic chk_addr(input string tag, input int addr, input logic [31:0] exp);
        result_address = 6'(addr);
        #1;
        check($sformatf("%s_addr%0d", tag, addr), final_output, exp);
    endtask

    task automatic compare_all(input string tag);
        for (int a = 0; a < 64; a++)
            chk_addr(tag, a, (a < 36) ? ref_ram[a] : 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    task automatic start_kernel(input int s, input int kw);
        @(negedge clk);
        stride       = 2'(s);
        kernel_width = 2'(kw);
        enable       = 1'b1;
        wait_ready(100);
        for (int k = 0; k < kw * kw; k++) begin
            strobe_signal_kernel = 1'b1;
            kernel_weight        = 8'(w_arr[k]);
            @(negedge clk);
            strobe_signal_kernel = 1'b0;
        end
    endtask

    task automatic send_px(input int v, input int idx);
        wait_ready(50);
        strobe_signal_pixel = 1'b1;
        pixel               = 8'(v);
        pixel_number        = 2'(idx);
        @(negedge clk);
        strobe_signal_pixel = 1'b0;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int s, kw;
        rst = 1'b0; enable = 1'b0;
        strobe_signal_pixel = 1'b0; strobe_signal_kernel = 1'b0;
        pixel = '0; stride = 2'd1; kernel_width = 2'd1; kernel_weight = '0;
        pixel_number = '0; result_address = '0;
        #12;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        chk_addr("rst_out", 0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Stride 1, 2x2 all-ones kernel, four ordered pixels.
        for (int k = 0; k < 4; k++) begin w_arr[k] = 1; px_idx[k] = k; end
        px_val[0] = 10; px_val[1] = 20; px_val[2] = 30; px_val[3] = 40;
        start_kernel(1, 2);
        for (int p = 0; p < 4; p++) send_px(px_val[p], px_idx[p]);
        wait_done(100);
        model_calc(1, 2, 4);
        compare_all("s1k2");
        chk_addr("s1k2_const", 7, 32'd100);
        chk_addr("s1k2_const", 8, 32'd60);
        chk_addr("s1k2_const", 13, 32'd70);
        go_idle();

        // Re-enable: result RAM is cleared over 36 cycles before ready rises.
        stride = 2'd1; kernel_width = 2'd2; enable = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("clear_cycles", 32'(cnt), 32'd36);
        model_calc(1, 2, 0);
        compare_all("cleared");
        go_idle();

        // Stride 2: non-overlapping windows.
        for (int k = 0; k < 4; k++) px_val[k] = k + 1;
        start_kernel(2, 2);
        for (int p = 0; p < 4; p++) send_px(px_val[p], px_idx[p]);
        wait_done(100);
        model_calc(2, 2, 4);
        compare_all("s2k2");
        chk_addr("s2k2_const", 21, 32'd4);
        chk_addr("s2k2_const", 18, 32'd3);
        go_idle();

        // Back-to-back strobes: second goes to the pending buffer, third is dropped.
        px_val[0] = 10; px_val[1] = 20; px_val[2] = 30; px_val[3] = 40;
        start_kernel(1, 2);
        wait_ready(50);
        strobe_signal_pixel = 1'b1; pixel = 8'd10; pixel_number = 2'd0;
        @(negedge clk);
        pixel = 8'd20; pixel_number = 2'd1;
        @(negedge clk);
        pixel = 8'd99; pixel_number = 2'd2;
        @(negedge clk);
        strobe_signal_pixel = 1'b0;
        send_px(30, 2);
        send_px(40, 3);
        wait_done(100);
        model_calc(1, 2, 4);
        compare_all("pending");
        go_idle();

        // Abort after the first tap: one word written, state back to idle.
        start_kernel(1, 2);
        wait_ready(50);
        strobe_signal_pixel = 1'b1; pixel = 8'd10; pixel_number = 2'd0;
        @(negedge clk);
        strobe_signal_pixel = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        chk_addr("abort", 0, 32'd10);
        chk_addr("abort", 1, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_idle_ready", 32'(ready), 32'd0);

        // Randomized strides, kernel sizes, weights and pixels.
        for (int it = 0; it < 5; it++) begin
            s  = int'($urandom_range(1, 3));
            kw = int'($urandom_range(1, 3));
            for (int k = 0; k < 9; k++) w_arr[k] = int'($urandom_range(0, 255));
            for (int p = 0; p < 4; p++) begin
                px_val[p] = int'($urandom_range(0, 255));
                px_idx[p] = int'($urandom_range(0, 3));
            end
            start_kernel(s, kw);
            for (int p = 0; p < 4; p++) send_px(px_val[p], px_idx[p]);
            wait_done(200);
            model_calc(s, kw, 4);
            compare_all($sformatf("rand%0d_s%0d_k%0d", it, s, kw));
            go_idle();
        end

        // Full-scale products accumulate without truncation; then async reset mid-DONE.
        w_arr[0] = 255;
        for (int p = 0; p < 4; p++) begin px_val[p] = 255; px_idx[p] = 0; end
        start_kernel(1, 1);
        for (int p = 0; p < 4; p++) send_px(255, 0);
        wait_done(100);
        chk_addr("maxval", 0, 32'd260100);
        model_calc(1, 1, 4);
        compare_all("maxval");
        result_address = 6'd0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_done", 32'(done), 32'd0);
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_out", final_output, 32'd0);
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_stays_idle", 32'(ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
